// File: rtl/dc_ctrl_pkg.sv
// ============================================================================
// Module : dc_ctrl_pkg
// Brief  : Shared types and header-field layout for the DC frame sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_CSUM    = 3'd2,
        ST_LOAD    = 3'd3,
        ST_LAUNCH  = 3'd4
    } state_t;

    localparam int MAGIC_MSB = 31;
    localparam int MAGIC_LSB = 28;
    localparam int TYPE_MSB  = 27;
    localparam int TYPE_LSB  = 24;
    localparam int MASK_MSB  = 23;
    localparam int MASK_LSB  = 0;

    localparam logic [3:0] TYPE_CFG    = 4'd0;
    localparam logic [3:0] TYPE_LAUNCH = 4'd1;

endpackage

`default_nettype wire

// File: rtl/dc_frame_sequencer_if.sv
// ============================================================================
// Module : dc_frame_sequencer_if
// Brief  : Show-ahead command-word FIFO read port (FIFO = master, sequencer = slave).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dc_frame_sequencer_if;
    logic [31:0] i_fifo_data;
    logic        i_fifo_empty;
    logic        o_fifo_deq;

    modport master (output i_fifo_data, output i_fifo_empty, input  o_fifo_deq);
    modport slave  (input  i_fifo_data, input  i_fifo_empty, output o_fifo_deq);
endinterface

`default_nettype wire

// File: rtl/dc_mask_scan.sv
// ============================================================================
// Module : dc_mask_scan
// Brief  : Finds the lowest set mask bit at or above a scan pointer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dc_mask_scan #(
    parameter int WIDTH = 24,
    parameter int PTR_W = $clog2(WIDTH + 1)
) (
    input  wire logic [WIDTH-1:0] i_mask,
    input  wire logic [PTR_W-1:0] i_ptr,
    output logic      [PTR_W-1:0] o_idx,
    output logic                  o_found
);

    // Descending walk so the lowest qualifying bit is the last one written.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_mask[i] && (PTR_W'(i) >= i_ptr)) begin
                o_idx   = PTR_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dc_frame_sequencer.sv
// ============================================================================
// Module : dc_frame_sequencer
// Brief  : Parses checksummed command frames, shadows config payload, loads DC channels.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dc_frame_sequencer
    import dc_ctrl_pkg::*;
#(
    parameter int         DAC_CHANNEL   = 24,
    parameter int         FRAME_WORDS   = 31,
    parameter int         TIMEOUT_WIDTH = 16,
    parameter logic [3:0] MAGIC         = 4'hA
) (
    input  wire logic                      i_clk,
    input  wire logic                      i_rst,
    dc_frame_sequencer_if.slave            fifo,
    input  wire logic [DAC_CHANNEL-1:0]    i_dc_busy,
    output logic      [FRAME_WORDS*32-1:0] o_regs,
    output logic      [DAC_CHANNEL-1:0]    o_load,
    output logic      [31:0]               o_launch_cmd,
    output logic                           o_launch_valid,
    output logic                           o_busy,
    output logic      [7:0]                o_err_cnt,
    output logic                           o_timeout
);

    localparam int PTR_W = $clog2(DAC_CHANNEL + 1);
    localparam int IDX_W = $clog2(FRAME_WORDS + 1);

    state_t                      state_q, state_d;
    logic                        is_cfg_q, is_cfg_d;
    logic [DAC_CHANNEL-1:0]      mask_q, mask_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [31:0]                 csum_q, csum_d;
    logic [TIMEOUT_WIDTH-1:0]    wait_q, wait_d;
    logic [FRAME_WORDS*32-1:0]   regs_q, regs_d;
    logic [31:0]                 hold_q, hold_d;
    logic [31:0]                 launch_cmd_q, launch_cmd_d;
    logic                        launch_valid_q, launch_valid_d;
    logic [7:0]                  err_cnt_q, err_cnt_d;

    logic                        pop;
    logic                        err_inc;
    logic                        timeout;
    logic [DAC_CHANNEL-1:0]      load_vec;
    logic [DAC_CHANNEL-1:0]      sel;
    logic [PTR_W-1:0]            scan_idx;
    logic                        scan_found;
    logic [23:0]                 hdr_mask;
    logic [3:0]                  hdr_type;

    dc_mask_scan #(
        .WIDTH (DAC_CHANNEL),
        .PTR_W (PTR_W)
    ) u_scan (
        .i_mask  (mask_q),
        .i_ptr   (ptr_q),
        .o_idx   (scan_idx),
        .o_found (scan_found)
    );

    assign hdr_mask = fifo.i_fifo_data[MASK_MSB:MASK_LSB];
    assign hdr_type = fifo.i_fifo_data[TYPE_MSB:TYPE_LSB];

    always_comb begin
        state_d        = state_q;
        is_cfg_d       = is_cfg_q;
        mask_d         = mask_q;
        ptr_d          = ptr_q;
        idx_d          = idx_q;
        csum_d         = csum_q;
        wait_d         = wait_q;
        regs_d         = regs_q;
        hold_d         = hold_q;
        launch_cmd_d   = launch_cmd_q;
        launch_valid_d = 1'b0;
        pop            = 1'b0;
        err_inc        = 1'b0;
        timeout        = 1'b0;
        load_vec       = '0;
        sel            = '0;

        // Strobes and pops are suppressed while reset is held.
        if (!i_rst) begin
            pop = !fifo.i_fifo_empty &&
                  (state_q == ST_IDLE || state_q == ST_PAYLOAD || state_q == ST_CSUM);
            case (state_q)
                ST_IDLE: if (pop) begin
                    if (fifo.i_fifo_data[MAGIC_MSB:MAGIC_LSB] == MAGIC &&
                        (hdr_type == TYPE_CFG || hdr_type == TYPE_LAUNCH)) begin
                        is_cfg_d = (hdr_type == TYPE_CFG);
                        mask_d   = hdr_mask[DAC_CHANNEL-1:0];
                        csum_d   = fifo.i_fifo_data;
                        idx_d    = '0;
                        state_d  = ST_PAYLOAD;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                ST_PAYLOAD: if (pop) begin
                    if (is_cfg_q) regs_d[{idx_q, 5'b0} +: 32] = fifo.i_fifo_data;
                    else          hold_d = fifo.i_fifo_data;
                    csum_d = csum_q ^ fifo.i_fifo_data;
                    idx_d  = idx_q + IDX_W'(1);
                    if (!is_cfg_q || idx_q == IDX_W'(FRAME_WORDS - 1)) state_d = ST_CSUM;
                end
                ST_CSUM: if (pop) begin
                    if (fifo.i_fifo_data != csum_q) begin
                        err_inc = 1'b1;
                        state_d = ST_IDLE;
                    end else if (is_cfg_q) begin
                        ptr_d   = '0;
                        wait_d  = '0;
                        state_d = (mask_q == '0) ? ST_IDLE : ST_LOAD;
                    end else begin
                        launch_cmd_d   = hold_q;
                        launch_valid_d = 1'b1;
                        state_d        = ST_LAUNCH;
                    end
                end
                ST_LOAD: begin
                    if (!scan_found) begin
                        state_d = ST_IDLE;
                    end else begin
                        sel[scan_idx] = 1'b1;
                        if (!i_dc_busy[scan_idx] || (&wait_q)) begin
                            if (i_dc_busy[scan_idx]) begin
                                timeout = 1'b1;
                                err_inc = 1'b1;
                            end else begin
                                load_vec = sel;
                            end
                            mask_d = mask_q & ~sel;
                            ptr_d  = scan_idx + PTR_W'(1);
                            wait_d = '0;
                            // Leave on the last channel so LOAD lasts popcount(mask) cycles.
                            if ((mask_q & ~sel) == '0) state_d = ST_IDLE;
                        end else begin
                            wait_d = wait_q + TIMEOUT_WIDTH'(1);
                        end
                    end
                end
                ST_LAUNCH: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end

        err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= ST_IDLE;
            is_cfg_q       <= 1'b0;
            mask_q         <= '0;
            ptr_q          <= '0;
            idx_q          <= '0;
            csum_q         <= '0;
            wait_q         <= '0;
            regs_q         <= '0;
            hold_q         <= '0;
            launch_cmd_q   <= '0;
            launch_valid_q <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            is_cfg_q       <= is_cfg_d;
            mask_q         <= mask_d;
            ptr_q          <= ptr_d;
            idx_q          <= idx_d;
            csum_q         <= csum_d;
            wait_q         <= wait_d;
            regs_q         <= regs_d;
            hold_q         <= hold_d;
            launch_cmd_q   <= launch_cmd_d;
            launch_valid_q <= launch_valid_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign fifo.o_fifo_deq = pop;
    assign o_regs          = regs_q;
    assign o_load          = load_vec;
    assign o_launch_cmd    = launch_cmd_q;
    assign o_launch_valid  = launch_valid_q;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_err_cnt       = err_cnt_q;
    assign o_timeout       = timeout;

endmodule

`default_nettype wire

// File: tb/tb_dc_frame_sequencer.sv
// ============================================================================
// Module : tb_dc_frame_sequencer
// Brief  : Directed self-checking bench for dc_frame_sequencer (short busy timeout).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dc_frame_sequencer;

    localparam int DAC_CHANNEL   = 24;
    localparam int FRAME_WORDS   = 31;
    localparam int TIMEOUT_WIDTH = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [DAC_CHANNEL-1:0]    dc_busy;
    logic [FRAME_WORDS*32-1:0] regs;
    logic [DAC_CHANNEL-1:0]    load;
    logic [31:0]               launch_cmd;
    logic                      launch_valid;
    logic                      busy;
    logic [7:0]                err_cnt;
    logic                      timeout;

    int checks   = 0;
    int failures = 0;
    logic bad;

    dc_frame_sequencer_if fifo ();

    dc_frame_sequencer #(
        .DAC_CHANNEL   (DAC_CHANNEL),
        .FRAME_WORDS   (FRAME_WORDS),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
        .MAGIC         (4'hA)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .fifo           (fifo),
        .i_dc_busy      (dc_busy),
        .o_regs         (regs),
        .o_load         (load),
        .o_launch_cmd   (launch_cmd),
        .o_launch_valid (launch_valid),
        .o_busy         (busy),
        .o_err_cnt      (err_cnt),
        .o_timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fifo.i_fifo_data  = w;
        fifo.i_fifo_empty = 1'b0;
        tick();
    endtask

    // Sends header, FRAME_WORDS payload words base+k and the XOR checksum.
    task automatic send_cfg(input logic [23:0] mask, input logic [31:0] base, input logic corrupt);
        logic [31:0] hdr;
        logic [31:0] cs;
        hdr = {4'hA, 4'h0, mask};
        cs  = hdr;
        push(hdr);
        for (int k = 0; k < FRAME_WORDS; k++) begin
            push(base + 32'(k));
            cs = cs ^ (base + 32'(k));
        end
        push(corrupt ? (cs ^ 32'h1) : cs);
        fifo.i_fifo_empty = 1'b1;
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        dc_busy           = '0;
        fifo.i_fifo_data  = '0;
        fifo.i_fifo_empty = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_regs",  64'(regs[31:0]), 64'h0);
        check("rst_err",   64'(err_cnt), 64'h0);
        check("rst_busy",  64'(busy), 64'h0);
        check("rst_strb",  {load, launch_valid, timeout}, 64'h0);
        rst = 1'b0;
        #1;
        check("rst_deq",   64'(fifo.o_fifo_deq), 64'h0);

        // Config frame, mask 0x5, no busy channels
        fifo.i_fifo_data  = 32'hA000_0005;
        fifo.i_fifo_empty = 1'b0;
        #1;
        check("idle_deq", 64'(fifo.o_fifo_deq), 64'h1);
        send_cfg(24'h000005, 32'h1000, 1'b0);
        check("cfg_load0", 64'(load), 64'h1);
        check("cfg_busy",  64'(busy), 64'h1);
        check("cfg_deq_in_load", 64'(fifo.o_fifo_deq), 64'h0);
        tick();
        check("cfg_load2", 64'(load), 64'h4);
        tick();
        check("cfg_done_load", 64'(load), 64'h0);
        check("cfg_done_busy", 64'(busy), 64'h0);
        check("cfg_w0",  64'(regs[31:0]),    64'h1000);
        check("cfg_w7",  64'(regs[255:224]), 64'h1007);
        check("cfg_w30", 64'(regs[991:960]), 64'h101E);

        // Channel 0 busy for the first 10 LOAD cycles
        dc_busy = 24'h000001;
        send_cfg(24'h000005, 32'h1000, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bad = bad | (load != '0) | timeout;
            tick();
        end
        check("wait_no_load", 64'(bad), 64'h0);
        dc_busy = '0;
        #1;
        check("wait_load0", 64'(load), 64'h1);
        tick();
        check("wait_load2", 64'(load), 64'h4);
        tick();
        check("wait_done", 64'(busy), 64'h0);
        check("wait_err",  64'(err_cnt), 64'h0);

        // Channel 2 permanently busy: skipped after 15 wait cycles
        dc_busy = 24'h000004;
        send_cfg(24'h000005, 32'h1000, 1'b0);
        check("to_load0", 64'(load), 64'h1);
        tick();
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bad = bad | (load != '0) | timeout;
            tick();
        end
        check("to_quiet", 64'(bad), 64'h0);
        check("to_pulse", {load, timeout}, 64'h1);
        tick();
        check("to_pulse_end", 64'(timeout), 64'h0);
        check("to_idle",  64'(busy), 64'h0);
        check("to_err",   64'(err_cnt), 64'h1);
        dc_busy = '0;

        // Launch frame
        push(32'hA100_0000);
        push(32'h0000_000F);
        push(32'hA100_000F);
        fifo.i_fifo_empty = 1'b1;
        #1;
        check("launch_valid", 64'(launch_valid), 64'h1);
        check("launch_cmd",   64'(launch_cmd), 64'hF);
        check("launch_noload", 64'(load), 64'h0);
        tick();
        check("launch_pulse_end", 64'(launch_valid), 64'h0);
        check("launch_idle", 64'(busy), 64'h0);

        // Bad checksum, bad magic word, then a good frame
        send_cfg(24'h000005, 32'h1000, 1'b1);
        check("badcs_err",  64'(err_cnt), 64'h2);
        check("badcs_idle", {load, busy}, 64'h0);
        push(32'h1234_5678);
        fifo.i_fifo_empty = 1'b1;
        #1;
        check("badmagic_err", 64'(err_cnt), 64'h3);
        check("badmagic_idle", 64'(busy), 64'h0);
        send_cfg(24'h000002, 32'h4000, 1'b0);
        check("resync_load1", 64'(load), 64'h2);
        check("resync_w1", 64'(regs[63:32]), 64'h4001);
        tick();
        check("resync_idle", {load, busy}, 64'h0);

        // Empty mask: frame accepted, zero loads
        send_cfg(24'h000000, 32'h5000, 1'b0);
        check("empty_mask", {load, busy}, 64'h0);
        check("empty_w0", 64'(regs[31:0]), 64'h5000);

        // Reset mid-PAYLOAD, then a normal frame
        push(32'hA000_0001);
        for (int k = 0; k < 5; k++) push(32'h6000 + 32'(k));
        fifo.i_fifo_empty = 1'b1;
        rst = 1'b1;
        tick();
        check("mrst_regs", 64'(regs[31:0]), 64'h0);
        check("mrst_err",  64'(err_cnt), 64'h0);
        check("mrst_cmd",  64'(launch_cmd), 64'h0);
        check("mrst_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        tick();
        check("post_rst_strb", {load, launch_valid, timeout, busy}, 64'h0);
        send_cfg(24'h800000, 32'h3000, 1'b0);
        check("post_rst_load23", 64'(load), 64'h800000);
        check("post_rst_w3", 64'(regs[127:96]), 64'h3003);
        tick();
        check("post_rst_idle", 64'(busy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dc_frame_sequencer.md
# dc_frame_sequencer

Controller between the 32-bit command word FIFO and the DC channel bank. It parses framed commands, checks each frame with an XOR checksum and holds the payload in a shadow register set. It then loads the DC channels selected by a channel mask one at a time, waiting while a target channel is busy. Launch frames are forwarded as a single command pulse.

## Interface
- DAC_CHANNEL, 24, number of DC channels; must be ≤ 24.
- FRAME_WORDS, 31, payload words in a config frame (DEPTH*3+1).
- TIMEOUT_WIDTH, 16, width of the per-channel busy-wait counter.
- MAGIC, 4'hA, required header bits [31:28].

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset: synchronous, active-high, on i_clk
- i_fifo_data  in  32  word FIFO head (show-ahead; valid when !i_fifo_empty)
- i_fifo_empty  in  1  FIFO empty
- o_fifo_deq  out  1  pop FIFO head this cycle
- i_dc_busy  in  DAC_CHANNEL  channel cannot accept a load
- o_regs  out  FRAME_WORDS*32  shadow payload; word k at [32k+31:32k]
- o_load  out  DAC_CHANNEL  one-hot load strobe
- o_launch_cmd  out  32  last accepted launch word
- o_launch_valid  out  1  one-cycle launch strobe
- o_busy  out  1  high whenever state ≠ IDLE
- o_err_cnt  out  8  saturating error count
- o_timeout  out  1  one-cycle pulse when a channel load is skipped

## Operation
- Header format: [31:28] magic, [27:24] type, [23:0] channel mask. Type 0 = config; type 1 = launch; all other types are errors.
- Frame length: header + N payload words + checksum word. N = FRAME_WORDS for config, N = 1 for launch.
- Checksum: XOR of the header and all payload words.
- States: IDLE, PAYLOAD, CSUM, LOAD, LAUNCH.
- o_fifo_deq = !i_fifo_empty while in IDLE, PAYLOAD or CSUM; it is 0 in every other state.
- IDLE: on a popped word, check magic and type.
  - Good magic, known type: latch the mask (mask bits ≥ DAC_CHANNEL are ignored), seed the running XOR with the header, clear the word index, go to PAYLOAD.
  - Bad magic or bad type: discard the word, err_cnt+1, stay in IDLE. This gives resync on the next word.
- PAYLOAD: each popped word goes to o_regs[index] (config) or a launch holding register (launch). XOR it into the running checksum; index+1. After the N-th word, go to CSUM.
- CSUM: compare the popped word with the running XOR.
  - Mismatch: err_cnt+1, go to IDLE, no load and no launch.
  - Match, config: go to LOAD with scan pointer 0.
  - Match, launch: go to LAUNCH.
- LOAD: the scan pointer finds the lowest set mask bit at or above itself.
  - If that channel is not busy: drive its o_load bit high for 1 cycle, clear the bit, advance.
  - If the channel is busy: increment the wait counter. At all-ones, skip the channel: clear the bit, pulse o_timeout, err_cnt+1.
  - The wait counter resets for each new channel.
  - Mask empty: go to IDLE. An empty mask on entry gives zero load pulses.
- LAUNCH: o_launch_cmd ← payload word; o_launch_valid = 1 for that cycle; then IDLE.
- o_err_cnt saturates at 255.
- o_regs changes only in PAYLOAD. It is stable through LOAD.
- Reset values: state IDLE; o_regs, o_launch_cmd, o_err_cnt = 0; o_load, o_launch_valid, o_timeout, o_busy, o_fifo_deq = 0.
- Reset mid-frame: the partial frame is discarded. No strobe is issued in the cycle after reset.

## Timing
- One FIFO word per cycle when not empty. An empty FIFO stalls the state machine with no timeout.
- First o_load is the cycle after the CSUM pop, provided the target is not busy.
- Non-busy channels load back-to-back, one per cycle. The config LOAD phase lasts popcount(mask) cycles.
- o_launch_valid is the cycle after the CSUM pop.
- Only one o_load bit is high in any cycle. o_load and o_launch_valid are never high in the same cycle.
- i_dc_busy is sampled in the same cycle as the load decision. If busy drops, the load pulse is issued that cycle.
- Worst-case per-channel wait: 2^TIMEOUT_WIDTH−1 cycles.

## Structure
- Package dc_ctrl_pkg holds:
  - the state enum;
  - header field localparams (MAGIC_MSB/LSB, TYPE_MSB/LSB, MASK_MSB/LSB);
  - type codes TYPE_CFG = 0, TYPE_LAUNCH = 1.
- Sub-module dc_mask_scan: combinational. Inputs are the mask and the pointer; outputs are the next set index and a found flag.
- Top level holds the FSM, counters and shadow registers.

## Test plan
- Config frame, mask 0x000005, payload k = 0x1000+k, correct checksum → o_regs word k = 0x1000+k. o_load = 0x1 then 0x4 on consecutive cycles; then IDLE.
- Same frame with i_dc_busy[0] held for 10 cycles → o_load[0] is asserted 10 cycles later, o_load[2] the cycle after.
- TIMEOUT_WIDTH = 4, channel 2 permanently busy → o_timeout pulses after 15 wait cycles, channel 2 never loads, o_err_cnt = 1.
- Launch frame: 0xA1000000, 0x0000000F, checksum 0xA100000F → o_launch_cmd = 0x0000000F, one-cycle o_launch_valid, no o_load.
- Bad checksum, then word 0x12345678, then a valid frame → o_err_cnt = 2; only the valid frame loads.
- Reset asserted mid-PAYLOAD → all outputs return to reset values; the next complete frame is processed normally.
